// File: rtl/glyph_text_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : glyph_text_streamer                                              |
// | Brief   : Renders a glyph string from an external row ROM as a serial      |
// |           1-bit pixel raster (row-major over the whole string), 1x or 2x.  |
// | Option  : GLYPH_INVERT_EN adds a per-character invert bit (char_inv_i).    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module glyph_text_streamer #(
    parameter int glyph_w_p    = 32,
    parameter int glyph_h_p    = 64,
    parameter int num_glyphs_p = 8,
    parameter int num_chars_p  = 8,
    parameter int code_w_p     = 4
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          char_we_i,
    input  logic [$clog2(num_chars_p)-1:0]                char_idx_i,
    input  logic [code_w_p-1:0]                           char_code_i,
`ifdef GLYPH_INVERT_EN
    input  logic                                          char_inv_i,
`endif
    input  logic                                          start_i,
    input  logic                                          scale_i,
    output logic                                          busy_o,
    output logic [$clog2(num_glyphs_p*glyph_h_p)-1:0]     rom_addr_o,
    input  logic [glyph_w_p-1:0]                          rom_data_i,
    output logic                                          pix_v_o,
    output logic                                          pix_o,
    output logic                                          pix_first_o,
    output logic                                          pix_eol_o,
    input  logic                                          ready_i,
    output logic                                          done_o
);

    localparam int IDX_W  = $clog2(num_chars_p);
    localparam int ADDR_W = $clog2(num_glyphs_p * glyph_h_p);
    localparam int ROW_W  = $clog2(glyph_h_p);
    localparam int BIT_W  = $clog2(glyph_w_p);

    localparam logic [IDX_W-1:0] LAST_CHAR = IDX_W'(num_chars_p - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(glyph_h_p - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(glyph_w_p - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                 state_q;
    logic [code_w_p-1:0]    buf_q [num_chars_p];
    logic                   scale_q;
    logic [IDX_W-1:0]       char_q;
    logic [ROW_W-1:0]       row_q;
    logic [BIT_W-1:0]       bit_q;
    logic                   line_rep_q;
    logic                   pix_rep_q;
    logic [glyph_w_p-1:0]   shift_q;
    logic                   busy_q;
    logic                   pix_v_q;
    logic                   pix_q;
    logic                   pix_first_q;
    logic                   pix_eol_q;
    logic                   done_q;
    logic [ADDR_W-1:0]      rom_addr_q;

    logic                   idx_ok;
    logic                   inv_cur;
    logic [code_w_p-1:0]    code_cur;
    logic [code_w_p-1:0]    start_code;
    logic [glyph_w_p-1:0]   load_data;
    logic [glyph_w_p-1:0]   shift_d;
    logic [IDX_W-1:0]       char_d;
    logic [ROW_W-1:0]       row_d;
    logic [BIT_W-1:0]       bit_d;

    function automatic logic code_ok(input logic [code_w_p-1:0] code);
        return int'(code) < num_glyphs_p;
    endfunction

    // Codes with no glyph park the ROM address at 0 and render blank.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [code_w_p-1:0] code,
                                                   input logic [ROW_W-1:0]    row);
        if (!code_ok(code)) begin
            return '0;
        end
        return ADDR_W'(int'(code) * glyph_h_p + int'(row));
    endfunction

    generate
        if ((1 << IDX_W) == num_chars_p) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_part
            assign idx_ok = (int'(char_idx_i) < num_chars_p);
        end
    endgenerate

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_chars_p; i++) begin
                buf_q[i] <= '0;
            end
        end else if (state_q == S_IDLE && char_we_i && idx_ok) begin
            buf_q[char_idx_i] <= char_code_i;
        end
    end

`ifdef GLYPH_INVERT_EN
    logic inv_q [num_chars_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_chars_p; i++) begin
                inv_q[i] <= 1'b0;
            end
        end else if (state_q == S_IDLE && char_we_i && idx_ok) begin
            inv_q[char_idx_i] <= char_inv_i;
        end
    end

    assign inv_cur = inv_q[char_q];
`else
    assign inv_cur = 1'b0;
`endif

    assign code_cur   = buf_q[char_q];
    // A write to slot 0 in the same cycle as start must steer the first fetch.
    assign start_code = (char_we_i && idx_ok && char_idx_i == '0) ? char_code_i : buf_q[0];
    assign load_data  = code_ok(code_cur) ? rom_data_i : '0;
    assign shift_d    = shift_q << 1;
    assign char_d     = char_q + IDX_W'(1);
    assign row_d      = row_q + ROW_W'(1);
    assign bit_d      = bit_q + BIT_W'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            scale_q     <= 1'b0;
            char_q      <= '0;
            row_q       <= '0;
            bit_q       <= '0;
            line_rep_q  <= 1'b0;
            pix_rep_q   <= 1'b0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            pix_v_q     <= 1'b0;
            pix_q       <= 1'b0;
            pix_first_q <= 1'b0;
            pix_eol_q   <= 1'b0;
            done_q      <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        scale_q    <= scale_i;
                        char_q     <= '0;
                        row_q      <= '0;
                        bit_q      <= '0;
                        line_rep_q <= 1'b0;
                        pix_rep_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        rom_addr_q <= row_addr(start_code, '0);
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_q     <= load_data;
                    pix_v_q     <= 1'b1;
                    pix_q       <= load_data[glyph_w_p-1] ^ inv_cur;
                    pix_first_q <= (row_q == '0) && (char_q == '0) && !line_rep_q;
                    pix_eol_q   <= (char_q == LAST_CHAR) && (LAST_BIT == '0) && !scale_q;
                    bit_q       <= '0;
                    pix_rep_q   <= 1'b0;
                    state_q     <= S_EMIT;
                end
                S_EMIT: begin
                    if (ready_i) begin
                        pix_first_q <= 1'b0;
                        if (scale_q && !pix_rep_q) begin
                            pix_rep_q <= 1'b1;
                            pix_eol_q <= (char_q == LAST_CHAR) && (bit_q == LAST_BIT);
                        end else begin
                            pix_rep_q <= 1'b0;
                            if (bit_q != LAST_BIT) begin
                                bit_q     <= bit_d;
                                shift_q   <= shift_d;
                                pix_q     <= shift_d[glyph_w_p-1] ^ inv_cur;
                                pix_eol_q <= (char_q == LAST_CHAR) && (bit_d == LAST_BIT) && !scale_q;
                            end else begin
                                pix_v_q   <= 1'b0;
                                pix_q     <= 1'b0;
                                pix_eol_q <= 1'b0;
                                bit_q     <= '0;
                                if (char_q != LAST_CHAR) begin
                                    char_q     <= char_d;
                                    rom_addr_q <= row_addr(buf_q[char_d], row_q);
                                    state_q    <= S_LOAD;
                                end else begin
                                    char_q <= '0;
                                    if (scale_q && !line_rep_q) begin
                                        line_rep_q <= 1'b1;
                                        rom_addr_q <= row_addr(buf_q[0], row_q);
                                        state_q    <= S_LOAD;
                                    end else begin
                                        line_rep_q <= 1'b0;
                                        if (row_q != LAST_ROW) begin
                                            row_q      <= row_d;
                                            rom_addr_q <= row_addr(buf_q[0], row_d);
                                            state_q    <= S_LOAD;
                                        end else begin
                                            rom_addr_q <= '0;
                                            done_q     <= 1'b1;
                                            state_q    <= S_DONE;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign rom_addr_o  = rom_addr_q;
    assign pix_v_o     = pix_v_q;
    assign pix_o       = pix_q;
    assign pix_first_o = pix_first_q;
    assign pix_eol_o   = pix_eol_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_glyph_text_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_glyph_text_streamer                                           |
// | Brief   : Scoreboard bench for glyph_text_streamer (16-row glyphs to keep  |
// |           frames short); expected pixels come from a bench ROM model.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_glyph_text_streamer;

    localparam int W  = 32;
    localparam int H  = 16;
    localparam int NG = 8;
    localparam int NC = 8;
    localparam int CW = 4;
    localparam int AW = $clog2(NG * H);
    localparam int LINE_1X = NC * W;
    localparam int BUDGET  = 40000;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           char_we_i = 1'b0;
    logic [2:0]     char_idx_i = '0;
    logic [CW-1:0]  char_code_i = '0;
    logic           char_inv_i = 1'b0;
    logic           start_i = 1'b0;
    logic           scale_i = 1'b0;
    logic           busy_o;
    logic [AW-1:0]  rom_addr_o;
    logic [W-1:0]   rom_data_i;
    logic           pix_v_o, pix_o, pix_first_o, pix_eol_o;
    logic           ready_i = 1'b1;
    logic           done_o;

    glyph_text_streamer #(
        .glyph_w_p   (W),
        .glyph_h_p   (H),
        .num_glyphs_p(NG),
        .num_chars_p (NC),
        .code_w_p    (CW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .char_we_i  (char_we_i),
        .char_idx_i (char_idx_i),
        .char_code_i(char_code_i),
`ifdef GLYPH_INVERT_EN
        .char_inv_i (char_inv_i),
`endif
        .start_i    (start_i),
        .scale_i    (scale_i),
        .busy_o     (busy_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .pix_v_o    (pix_v_o),
        .pix_o      (pix_o),
        .pix_first_o(pix_first_o),
        .pix_eol_o  (pix_eol_o),
        .ready_i    (ready_i),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rom_word(input int addr);
        logic [7:0] a;
        a = addr[7:0];
        return {a, ~a, a * 8'd3 + 8'd1, a ^ 8'h5A};
    endfunction

    always_comb rom_data_i = rom_word(int'(rom_addr_o));

    int            n_cmp = 0;
    int            n_bad = 0;
    int            pop_cnt = 0;
    int            done_cnt = 0;
    bit            mon_en = 1'b0;
    bit            rand_ready = 1'b0;
    bit            hold_valid = 1'b0;
    logic [2:0]    held;
    logic [2:0]    exp_q [$];
    logic [CW-1:0] m_code [NC];
    logic          m_inv  [NC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected raster for the current string model: {pix, first, eol} per pixel.
    task automatic gen_frame(input bit s);
        logic [W-1:0] word;
        logic         p;
        for (int row = 0; row < H; row++)
            for (int lr = 0; lr <= int'(s); lr++)
                for (int c = 0; c < NC; c++) begin
                    word = (int'(m_code[c]) < NG) ? rom_word(int'(m_code[c]) * H + row) : '0;
                    for (int b = 0; b < W; b++)
                        for (int pr = 0; pr <= int'(s); pr++) begin
                            p = word[W-1-b] ^ m_inv[c];
                            exp_q.push_back({p,
                                             (row == 0 && lr == 0 && c == 0 && b == 0 && pr == 0),
                                             (c == NC-1 && b == W-1 && pr == int'(s))});
                        end
                end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops on every handshake, checks hold-stability across stalls.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done_o) done_cnt++;
            if (pix_v_o) begin
                if (hold_valid) check("stall_hold", {29'd0, pix_o, pix_first_o, pix_eol_o}, {29'd0, held});
                if (ready_i) begin
                    hold_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", 32'd1, 32'd0);
                    end else begin
                        check($sformatf("pixel%0d{pix,first,eol}", pop_cnt),
                              {29'd0, pix_o, pix_first_o, pix_eol_o}, {29'd0, exp_q.pop_front()});
                    end
                    pop_cnt++;
                end else begin
                    hold_valid = 1'b1;
                    held = {pix_o, pix_first_o, pix_eol_o};
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic write_char(input int idx, input int code, input bit inv);
        @(posedge clk);
        #1;
        char_we_i   = 1'b1;
        char_idx_i  = 3'(idx);
        char_code_i = CW'(code);
        char_inv_i  = inv;
        @(posedge clk);
        #1;
        char_we_i = 1'b0;
        m_code[idx] = CW'(code);
`ifdef GLYPH_INVERT_EN
        m_inv[idx] = inv;
`endif
    endtask

    task automatic start_frame(input bit s);
        gen_frame(s);
        pop_cnt  = 0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        scale_i = s;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
    endtask

    task automatic wait_frame(input string nm);
        int i;
        for (i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            if (done_cnt != 0) break;
        end
        check({nm, "_timeout"}, {31'd0, (i == BUDGET)}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check({nm, "_done_pulses"}, done_cnt, 32'd1);
        check({nm, "_leftover"}, exp_q.size(), 32'd0);
        check({nm, "_busy_end"}, {31'd0, busy_o}, 32'd0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_busy"},  {31'd0, busy_o},      32'd0);
        check({nm, "_pixv"},  {31'd0, pix_v_o},     32'd0);
        check({nm, "_pix"},   {31'd0, pix_o},       32'd0);
        check({nm, "_first"}, {31'd0, pix_first_o}, 32'd0);
        check({nm, "_eol"},   {31'd0, pix_eol_o},   32'd0);
        check({nm, "_done"},  {31'd0, done_o},      32'd0);
        check({nm, "_addr"},  {{(32-AW){1'b0}}, rom_addr_o}, 32'd0);
    endtask

    initial begin
        int i;
        for (int k = 0; k < NC; k++) begin
            m_code[k] = '0;
            m_inv[k]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        mon_en  = 1'b1;

        // Full alphabet, 1x, ready held high.
        for (int k = 0; k < NC; k++) write_char(k, k, 1'b0);
        start_frame(1'b0);
        wait_frame("alpha_1x");

        // Same string under random backpressure.
        rand_ready = 1'b1;
        start_frame(1'b0);
        wait_frame("alpha_stall");
        rand_ready = 1'b0;

        // 2x with one real glyph, the rest out-of-range codes.
        write_char(0, 2, 1'b0);
        for (int k = 1; k < NC; k++) write_char(k, 15, 1'b0);
        start_frame(1'b1);
        wait_frame("scale_2x");

        // Writes and start while busy are ignored.
        start_frame(1'b0);
        repeat (200) @(posedge clk);
        #1;
        char_we_i   = 1'b1;
        char_idx_i  = 3'd0;
        char_code_i = CW'(5);
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        char_we_i = 1'b0;
        start_i   = 1'b0;
        check("busy_during_poke", {31'd0, busy_o}, 32'd1);
        wait_frame("busy_poke");
        start_frame(1'b0);
        wait_frame("after_poke");

        // Asynchronous reset in the middle of line 10.
        for (int k = 0; k < NC; k++) write_char(k, NC - 1 - k, 1'b0);
        start_frame(1'b0);
        for (i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            if (pop_cnt >= 10 * LINE_1X + 40) break;
        end
        check("line10_timeout", {31'd0, (i == BUDGET)}, 32'd0);
        #3;
        reset_i = 1'b1;
        #1;
        mon_en = 1'b0;
        check_idle_outputs("midreset");
        exp_q.delete();
        hold_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        mon_en  = 1'b1;
        for (int k = 0; k < NC; k++) begin
            m_code[k] = '0;
            m_inv[k]  = 1'b0;
        end
        start_frame(1'b0);
        wait_frame("post_reset");

`ifdef GLYPH_INVERT_EN
        write_char(3, 9, 1'b1);
        write_char(0, 0, 1'b1);
        start_frame(1'b0);
        wait_frame("invert");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
